// File: rtl/para_pkg.sv
// Shared definitions for the measurement scheduler: FSM state encoding, result
// record layout and the ring value reported on timeout.
package para_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGap,
    StWin,
    StDrain,
    StStore
  } sched_state_e;

  // Result record layout: {timeout, seq[14:0], ring[15:0]}
  localparam int unsigned TO_BIT   = 31;
  localparam int unsigned SEQ_MSB  = 30;
  localparam int unsigned RING_MSB = 15;

  localparam logic [15:0] RING_TIMEOUT = 16'hFFFF;

  function automatic logic [31:0] pack_rec(logic to, logic [14:0] seq, logic [15:0] ring);
    logic [31:0] rec;
    rec                       = '0;
    rec[TO_BIT]               = to;
    rec[SEQ_MSB:RING_MSB+1]   = seq;
    rec[RING_MSB:0]           = ring;
    return rec;
  endfunction

endpackage

// File: rtl/para_res_fifo.sv
// Synchronous result FIFO with registered storage and combinational head.
// Ports:
//   clk_sys, rst      clock, synchronous active-high reset (clears contents)
//   push_i, wdata_i   write request and record
//   pop_i             read request; ignored when empty
//   head_o            record at the read pointer
//   full_o, empty_o   fill status
//   drop_o            push rejected because full with no same-cycle pop
module para_res_fifo #(
  parameter int unsigned AddrW = 3,
  parameter int unsigned DataW = 32
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             push_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             pop_i,
  output logic [DataW-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int unsigned Depth = 1 << AddrW;
  localparam logic [AddrW:0] DepthCnt = Depth[AddrW:0];

  logic [DataW-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             pop_ok, push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthCnt);
  assign pop_ok  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & ~push_ok;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/para_sched.sv
// Measurement scheduler: runs cfg_cnt windows separated by gaps, gates the
// sample stream into the hit detector during windows, and records one result
// (ring count or timeout) per window into an 8-entry FIFO.
// Ports:
//   clk_sys, rst                    clock, synchronous active-high reset
//   sm_data_in, sm_vld_in           samples from the sample mux
//   sm_data, sm_vld                 registered, window-gated samples to the hit detector
//   ph_ring, ph_vld                 ring result from the hit detector
//   cfg_start, cfg_abort            run control pulses
//   cfg_cnt, cfg_win, cfg_gap       run configuration, latched at start
//   res_rd, res_data, res_empty     result FIFO readout
//   stu_busy, stu_done, stu_ovf     status
module para_sched
  import para_pkg::*;
#(
  parameter int unsigned FIFO_AW   = 3,
  parameter int unsigned DRAIN_LEN = 16
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [15:0] sm_data_in,
  input  logic        sm_vld_in,
  output logic [15:0] sm_data,
  output logic        sm_vld,
  input  logic [15:0] ph_ring,
  input  logic        ph_vld,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  logic [15:0] cfg_cnt,
  input  logic [31:0] cfg_win,
  input  logic [31:0] cfg_gap,
  input  logic        res_rd,
  output logic [31:0] res_data,
  output logic        res_empty,
  output logic        stu_busy,
  output logic [15:0] stu_done,
  output logic        stu_ovf
);

  localparam logic [31:0] DrainLast = 32'(DRAIN_LEN - 1);

  sched_state_e state_q;
  logic [31:0]  cnt_q;        // cycles left in the current phase, minus one
  logic [15:0]  run_cnt_q;
  logic [31:0]  gap_last_q;   // max(gap,1) - 1
  logic [31:0]  win_last_q;   // max(win,1) - 1
  logic [15:0]  seq_q;
  logic [15:0]  done_q;
  logic         ovf_q;
  logic         to_q;
  logic [15:0]  ring_q;
  logic [15:0]  sm_data_q;
  logic         sm_vld_q;

  logic         push;
  logic         fifo_full;
  logic         fifo_drop;
  logic [31:0]  rec;

  // Abort wins over the STORE push, so the pending record is simply lost.
  assign push = (state_q == StStore) & ~cfg_abort;
  assign rec  = pack_rec(to_q, seq_q[14:0], ring_q);

  para_res_fifo #(
    .AddrW (FIFO_AW),
    .DataW (32)
  ) u_res_fifo (
    .clk_sys (clk_sys),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (rec),
    .pop_i   (res_rd),
    .head_o  (res_data),
    .full_o  (fifo_full),
    .empty_o (res_empty),
    .drop_o  (fifo_drop)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      run_cnt_q  <= '0;
      gap_last_q <= '0;
      win_last_q <= '0;
      seq_q      <= '0;
      done_q     <= '0;
      ovf_q      <= 1'b0;
      to_q       <= 1'b0;
      ring_q     <= '0;
      sm_data_q  <= '0;
      sm_vld_q   <= 1'b0;
    end else begin
      sm_data_q <= sm_data_in;
      sm_vld_q  <= sm_vld_in & (state_q == StWin);
      if (fifo_drop) begin
        ovf_q <= 1'b1;
      end
      if (cfg_abort) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cfg_start && (cfg_cnt != '0)) begin
              state_q    <= StGap;
              done_q     <= '0;
              ovf_q      <= 1'b0;
              seq_q      <= '0;
              run_cnt_q  <= cfg_cnt;
              gap_last_q <= (cfg_gap == '0) ? '0 : cfg_gap - 1;
              win_last_q <= (cfg_win == '0) ? '0 : cfg_win - 1;
              cnt_q      <= (cfg_gap == '0) ? '0 : cfg_gap - 1;
            end
          end
          StGap: begin
            if (cnt_q == '0) begin
              state_q <= StWin;
              cnt_q   <= win_last_q;
            end else begin
              cnt_q <= cnt_q - 1;
            end
          end
          StWin: begin
            if (ph_vld) begin
              ring_q  <= ph_ring;
              to_q    <= 1'b0;
              state_q <= StStore;
            end else if (cnt_q == '0) begin
              state_q <= StDrain;
              cnt_q   <= DrainLast;
            end else begin
              cnt_q <= cnt_q - 1;
            end
          end
          StDrain: begin
            if (ph_vld) begin
              ring_q  <= ph_ring;
              to_q    <= 1'b0;
              state_q <= StStore;
            end else if (cnt_q == '0) begin
              ring_q  <= RING_TIMEOUT;
              to_q    <= 1'b1;
              state_q <= StStore;
            end else begin
              cnt_q <= cnt_q - 1;
            end
          end
          StStore: begin
            seq_q  <= seq_q + 16'd1;
            done_q <= done_q + 16'd1;
            if ((done_q + 16'd1) == run_cnt_q) begin
              state_q <= StIdle;
            end else begin
              state_q <= StGap;
              cnt_q   <= gap_last_q;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sm_data  = sm_data_q;
  assign sm_vld   = sm_vld_q;
  assign stu_busy = (state_q != StIdle);
  assign stu_done = done_q;
  assign stu_ovf  = ovf_q;

  // fifo_full is only needed inside the FIFO's own push decision.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_para_sched.sv
module tb_para_sched;
  import para_pkg::*;

  localparam int DrainLen = 16;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [15:0] sm_data_in;
  logic        sm_vld_in;
  logic [15:0] sm_data;
  logic        sm_vld;
  logic [15:0] ph_ring;
  logic        ph_vld;
  logic        cfg_start;
  logic        cfg_abort;
  logic [15:0] cfg_cnt;
  logic [31:0] cfg_win;
  logic [31:0] cfg_gap;
  logic        res_rd;
  logic [31:0] res_data;
  logic        res_empty;
  logic        stu_busy;
  logic [15:0] stu_done;
  logic        stu_ovf;

  para_sched #(
    .FIFO_AW   (3),
    .DRAIN_LEN (DrainLen)
  ) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .sm_data_in (sm_data_in),
    .sm_vld_in  (sm_vld_in),
    .sm_data    (sm_data),
    .sm_vld     (sm_vld),
    .ph_ring    (ph_ring),
    .ph_vld     (ph_vld),
    .cfg_start  (cfg_start),
    .cfg_abort  (cfg_abort),
    .cfg_cnt    (cfg_cnt),
    .cfg_win    (cfg_win),
    .cfg_gap    (cfg_gap),
    .res_rd     (res_rd),
    .res_data   (res_data),
    .res_empty  (res_empty),
    .stu_busy   (stu_busy),
    .stu_done   (stu_done),
    .stu_ovf    (stu_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_q[$];  // expected FIFO contents, capped at 8
  logic        model_ovf = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; in_win says whether the schedule puts this cycle inside a window.
  task automatic step(bit in_win);
    logic [15:0] exp_d;
    logic        exp_v;
    sm_data_in = 16'($urandom);
    sm_vld_in  = 1'($urandom);
    exp_d      = sm_data_in;
    exp_v      = sm_vld_in & in_win;
    @(posedge clk_sys);
    #1;
    chk("sm_data", 32'(sm_data), 32'(exp_d));
    chk("sm_vld", 32'(sm_vld), 32'(exp_v));
  endtask

  task automatic check_reset_values();
    chk("rst_sm_data", 32'(sm_data), 32'h0);
    chk("rst_sm_vld", 32'(sm_vld), 32'h0);
    chk("rst_res_empty", 32'(res_empty), 32'h1);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_busy", 32'(stu_busy), 32'h0);
    chk("rst_done", 32'(stu_done), 32'h0);
    chk("rst_ovf", 32'(stu_ovf), 32'h0);
  endtask

  // fmode: -1 random, 0 reply in window, 1 reply in drain, 2 timeout.
  // foff/fring: -1 random. abort_k: window aborted together with its reply.
  task automatic do_run(int cnt, int gap, int win, int fmode, int foff, int fring,
                        int abort_k, bit pop_full);
    int geff;
    int weff;
    geff = (gap == 0) ? 1 : gap;
    weff = (win == 0) ? 1 : win;
    cfg_cnt   = 16'(cnt);
    cfg_gap   = 32'(gap);
    cfg_win   = 32'(win);
    cfg_start = 1'b1;
    step(0);
    cfg_start = 1'b0;
    model_ovf = 1'b0;
    chk("start_busy", 32'(stu_busy), 32'h1);
    chk("start_done", 32'(stu_done), 32'h0);
    chk("start_ovf", 32'(stu_ovf), 32'h0);
    // Config is latched; scramble it to prove it is not re-sampled.
    cfg_cnt = 16'($urandom);
    cfg_gap = 32'($urandom_range(0, 50));
    cfg_win = 32'($urandom_range(0, 50));
    for (int k = 0; k < cnt; k++) begin
      int          mode;
      int          off;
      bit          hit;
      logic [15:0] ring;
      logic [31:0] rec;
      mode = (fmode < 0) ? int'($urandom_range(0, 2)) : fmode;
      if (k == abort_k) mode = 0;
      ring = (fring < 0) ? 16'($urandom) : 16'(fring);
      if (foff >= 0) off = foff;
      else off = int'($urandom_range(0, (mode == 0) ? weff - 1 : DrainLen - 1));
      // Gap: stray strobes and restarts must be ignored.
      for (int i = 0; i < geff; i++) begin
        cfg_start = ($urandom_range(0, 3) == 0);
        ph_vld    = ($urandom_range(0, 3) == 0);
        ph_ring   = 16'($urandom);
        step(0);
      end
      cfg_start = 1'b0;
      ph_vld    = 1'b0;
      hit       = 1'b0;
      for (int i = 0; i < weff && !hit; i++) begin
        ph_ring = 16'($urandom);
        if (mode == 0 && i == off) begin
          ph_vld  = 1'b1;
          ph_ring = ring;
          hit     = 1'b1;
          if (k == abort_k) cfg_abort = 1'b1;
        end
        step(1);
        ph_vld = 1'b0;
      end
      if (k == abort_k) begin
        cfg_abort = 1'b0;
        chk("abort_busy", 32'(stu_busy), 32'h0);
        chk("abort_done", 32'(stu_done), 32'(k));
        step(0);
        chk("abort_idle", 32'(stu_busy), 32'h0);
        chk("abort_empty", 32'(res_empty), 32'(model_q.size() == 0));
        if (model_q.size() > 0) chk("abort_head", res_data, model_q[0]);
        return;
      end
      for (int i = 0; i < DrainLen && !hit; i++) begin
        ph_ring = 16'($urandom);
        if (mode == 1 && i == off) begin
          ph_vld  = 1'b1;
          ph_ring = ring;
          hit     = 1'b1;
        end
        step(0);
        ph_vld = 1'b0;
      end
      rec = hit ? {1'b0, 15'(k), ring} : {1'b1, 15'(k), RING_TIMEOUT};
      chk("pre_store_empty", 32'(res_empty), 32'(model_q.size() == 0));
      // STORE cycle: a strobe here is discarded.
      ph_vld  = 1'($urandom);
      ph_ring = 16'($urandom);
      res_rd  = pop_full && (model_q.size() == 8);
      if (res_rd) void'(model_q.pop_front());
      if (model_q.size() < 8) model_q.push_back(rec);
      else model_ovf = 1'b1;
      step(0);
      ph_vld = 1'b0;
      res_rd = 1'b0;
      chk("store_done", 32'(stu_done), 32'(k + 1));
      chk("store_busy", 32'(stu_busy), 32'(k + 1 < cnt));
      chk("store_ovf", 32'(stu_ovf), 32'(model_ovf));
      chk("store_empty", 32'(res_empty), 32'h0);
      chk("store_head", res_data, model_q[0]);
    end
  endtask

  task automatic drain_fifo();
    while (model_q.size() > 0) begin
      chk("rd_empty", 32'(res_empty), 32'h0);
      chk("rd_data", res_data, model_q[0]);
      res_rd = 1'b1;
      step(0);
      res_rd = 1'b0;
      void'(model_q.pop_front());
    end
    chk("rd_final_empty", 32'(res_empty), 32'h1);
    res_rd = 1'b1;  // pop on empty is ignored
    step(0);
    res_rd = 1'b0;
    chk("rd_empty_pop", 32'(res_empty), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    sm_data_in = 16'h0;
    sm_vld_in  = 1'b0;
    ph_ring    = 16'h0;
    ph_vld     = 1'b0;
    cfg_start  = 1'b0;
    cfg_abort  = 1'b0;
    cfg_cnt    = 16'h0;
    cfg_win    = 32'h0;
    cfg_gap    = 32'h0;
    res_rd     = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    rst = 1'b0;
    check_reset_values();

    // Zero-count start is ignored.
    cfg_cnt   = 16'h0;
    cfg_win   = 32'd5;
    cfg_gap   = 32'd5;
    cfg_start = 1'b1;
    step(0);
    cfg_start = 1'b0;
    chk("cnt0_busy", 32'(stu_busy), 32'h0);

    // Normal run.
    do_run(3, 4, 20, 0, 5, 16'h0012, -1, 1'b0);
    drain_fifo();
    // Timeout, then late reply at drain cycle 10.
    do_run(1, 2, 8, 2, -1, -1, -1, 1'b0);
    drain_fifo();
    do_run(1, 3, 8, 1, 10, -1, -1, 1'b0);
    drain_fifo();

    // Random runs, gap/win including 0.
    repeat (6) begin
      do_run(int'($urandom_range(1, 4)), int'($urandom_range(0, 6)),
             int'($urandom_range(0, 6)), -1, -1, -1, -1, 1'b0);
      drain_fifo();
    end

    // Overflow, then push+pop on full.
    do_run(10, 1, 2, -1, -1, -1, -1, 1'b0);
    chk("ovf_sticky", 32'(stu_ovf), 32'h1);
    drain_fifo();
    do_run(9, 1, 2, -1, -1, -1, -1, 1'b1);
    chk("pushpop_ovf", 32'(stu_ovf), 32'h0);
    drain_fifo();

    // Abort together with the reply in window 2.
    do_run(3, 2, 10, 0, 3, -1, 1, 1'b0);
    chk("abort_done_kept", 32'(stu_done), 32'h1);
    drain_fifo();

    // Mid-window reset with a non-empty FIFO.
    do_run(1, 1, 1, 2, -1, -1, -1, 1'b0);
    cfg_cnt   = 16'd2;
    cfg_gap   = 32'd1;
    cfg_win   = 32'd10;
    cfg_start = 1'b1;
    step(0);
    cfg_start = 1'b0;
    step(0);
    repeat (3) step(1);
    rst        = 1'b1;
    sm_data_in = 16'hA5A5;
    sm_vld_in  = 1'b1;
    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    model_q.delete();
    check_reset_values();
    do_run(2, 0, 0, -1, -1, -1, -1, 1'b0);
    drain_fifo();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/para_sched.md
# para_sched

Measurement scheduler in front of `para_hit`. It runs a programmed number of measurement windows separated by idle gaps, and gates the sample stream into the hit detector only while a window is open. It captures each `ph_ring` result, or records a timeout when none arrives, tags it with a sequence index, and buffers the records in an 8-entry FIFO for register readout. It sits between the sample-mux output and `para_hit` in `para_top`.

## Interface
Parameters:
- `FIFO_AW`, 3: result FIFO address width (depth 2^FIFO_AW = 8).
- `DRAIN_LEN`, 16: cycles after window close during which a late `ph_vld` is still accepted.

Ports (one clock; reset is synchronous and active-high):
- `clk_sys`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `sm_data_in`  in  16  sample from the sample mux.
- `sm_vld_in`  in  1  sample valid.
- `sm_data`  out  16  sample to `para_hit`.
- `sm_vld`  out  1  gated valid to `para_hit`.
- `ph_ring`  in  16  ring count from `para_hit`.
- `ph_vld`  in  1  ring result strobe.
- `cfg_start`  in  1  single-cycle pulse; starts a run.
- `cfg_abort`  in  1  single-cycle pulse; stops a run.
- `cfg_cnt`  in  16  windows per run.
- `cfg_win`  in  32  window length in clocks.
- `cfg_gap`  in  32  gap length in clocks.
- `res_rd`  in  1  pop strobe; one record per cycle.
- `res_data`  out  32  FIFO head: {timeout, seq[14:0], ring[15:0]}.
- `res_empty`  out  1  FIFO empty.
- `stu_busy`  out  1  state ≠ IDLE.
- `stu_done`  out  16  windows completed in the current or last run.
- `stu_ovf`  out  1  sticky: a record was dropped.

## Operation
- States are IDLE, GAP, WIN, DRAIN and STORE.
- IDLE → GAP on `cfg_start` when `cfg_cnt` ≠ 0.
  - On that transition: `stu_done`←0, `stu_ovf`←0, seq←0, and `cfg_*` are latched. Config is not re-sampled mid-run.
  - `cfg_start` with `cfg_cnt`=0 is ignored.
  - `cfg_start` while busy is ignored.
- GAP: counts max(`cfg_gap`,1) clocks, then → WIN.
- WIN: counts max(`cfg_win`,1) clocks.
  - `ph_vld` in WIN captures `ph_ring`, clears the timeout flag and → STORE. The window closes early.
  - Count expiry without `ph_vld` → DRAIN.
- DRAIN: gate closed for up to `DRAIN_LEN` clocks.
  - `ph_vld` → capture, → STORE.
  - Expiry → timeout flag=1, ring=16'hFFFF, → STORE.
- STORE: one cycle. Pushes {flag, seq[14:0], ring}, then seq+1 and `stu_done`+1.
  - If `stu_done`+1 == `cfg_cnt` → IDLE, else → GAP.
- `ph_vld` in IDLE, GAP or STORE is discarded.
- `cfg_abort` in any state → IDLE next cycle. It has priority over every other transition, including a same-cycle `ph_vld` or STORE push.
  - Any pending record is dropped, not pushed.
  - FIFO contents, `stu_done` and `stu_ovf` are kept.
- Gate: `sm_data`/`sm_vld` are registered.
  - `sm_data`(t+1) = `sm_data_in`(t).
  - `sm_vld`(t+1) = `sm_vld_in`(t) & (state(t)==WIN).
- FIFO:
  - `res_data` shows the head combinationally from the registered array.
  - `res_rd` when empty is ignored.
  - A push when full with no same-cycle `res_rd` drops the record and sets `stu_ovf`. A push and pop in the same cycle on a full FIFO both succeed.
  - Pointers wrap modulo 8; fill level is held in a 4-bit count.
- `seq` is 16 bits internally; only bits [14:0] are stored.

## Timing
- Reset values:
  - state=IDLE.
  - `sm_data`=0, `sm_vld`=0.
  - `res_empty`=1, `res_data`=0 (empty array).
  - `stu_busy`=0, `stu_done`=0, `stu_ovf`=0.
  - FIFO pointers and count = 0.
- A mid-run reset behaves exactly like the reset values above; FIFO contents are lost.
- `cfg_start` at cycle 0 → `stu_busy`=1 at cycle 1. GAP occupies cycles 1..G, WIN starts at cycle G+1.
- The first gated `sm_vld` appears at cycle G+2.
- `ph_vld` at cycle t → STORE at t+1 → `res_empty`=0 at t+2. The next GAP starts at t+2.
- Timeout path length: W window cycles + `DRAIN_LEN` cycles + 1 STORE cycle.
- A pop at t reflects in `res_data`/`res_empty` at t+1.

## Structure
- Shared package `para_pkg` holds the state enum, the record field offsets (TO_BIT=31, SEQ_MSB=30, RING_MSB=15) and `RING_TIMEOUT`=16'hFFFF.
- One sub-module, `para_res_fifo`: a synchronous FIFO with push, pop, full, empty and head-out.
- The FSM, counters and gate live in `para_sched`. `para_top` instantiates `para_sched` ahead of `para_hit`.

## Test plan
- Normal run: `cfg_cnt`=3, gap=4, win=20, `ph_vld` with ring=0x0012 at 5 clocks into each window → 3 records, seq 0/1/2, flag 0, ring 0x0012; `stu_done`=3; `stu_busy` falls one cycle after the third STORE.
- Timeout: `cfg_cnt`=1, win=8, no `ph_vld` → a single record 0x8000FFFF, 8+16+1 cycles after WIN entry. A late `ph_vld` at DRAIN cycle 10 instead yields flag 0 with the captured ring.
- Gating: constant `sm_vld_in`=1 → `sm_vld` high exactly for win cycles per window, delayed one cycle; low in GAP, DRAIN and IDLE.
- Overflow: `cfg_cnt`=10, no reads → 8 records stored, `stu_ovf`=1, seq 0..7 read back. A simultaneous push and pop on full keeps `stu_ovf`=0.
- Abort: `cfg_abort` in the same cycle as `ph_vld` in window 2 → IDLE next cycle, no record for seq 1, `stu_done`=1, FIFO retains seq 0.
- Reset and degenerate config: `rst` mid-WIN → all outputs at reset values next cycle. `cfg_cnt`=0 start is ignored. gap=0 and win=0 each behave as 1.
